// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA-3 / Keccak padder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sha3_pkg;

    typedef enum logic [1:0] {
        MODE_224 = 2'd0,
        MODE_256 = 2'd1,
        MODE_384 = 2'd2,
        MODE_512 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        FULL   = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [7:0] DOMAIN_KECCAK = 8'h01;
    localparam logic [7:0] DOMAIN_SHA3   = 8'h06;
    localparam logic [7:0] PAD_END       = 8'h80;

    // Sponge rate in bits for each digest size.
    function automatic logic [10:0] rate_bits(input logic [1:0] mode);
        case (mode_e'(mode))
            MODE_224: rate_bits = 11'd1152;
            MODE_256: rate_bits = 11'd1088;
            MODE_384: rate_bits = 11'd832;
            default:  rate_bits = 11'd576;
        endcase
    endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Pads the final message word: keeps bytes below byte_num, inserts the domain byte, zeroes the rest.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module sha3_pad_word
    import sha3_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0]            word,
    input  logic [$clog2(W/8)-1:0]  byte_num,
    input  logic [7:0]              domain,
    input  logic                    final_pos,
    output logic [W-1:0]            padded
);

    localparam int NB   = W / 8;
    localparam int BN_W = $clog2(NB);

    // Byte-wise select, then fold in the pad-end bit when this word closes the block.
    always_comb begin
        padded = '0;
        for (int i = 0; i < NB; i++) begin
            if (BN_W'(i) < byte_num) begin
                padded[i*8 +: 8] = word[i*8 +: 8];
            end else if (BN_W'(i) == byte_num) begin
                padded[i*8 +: 8] = domain;
            end
        end
        if (final_pos) begin
            padded[W-1 -: 8] = padded[W-1 -: 8] | PAD_END;
        end
    end

endmodule

// File: rtl/sha3_padder_multi.sv
// Packs a byte-granular W-bit word stream into rate-sized padded blocks (rate chosen per message).
// Latency: out_ready rises the cycle after the block-completing word is accepted.
// Backpressure: buffer_full holds off input while a block waits for f_ack; input is dropped after the last block.
module sha3_padder_multi
    import sha3_pkg::*;
#(
    parameter int W        = 64,
    parameter int MAX_RATE = 1152
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [W-1:0]            in,
    input  logic                    in_ready,
    input  logic                    is_last,
    input  logic [$clog2(W/8)-1:0]  byte_num,
    input  logic [1:0]              mode,
    input  logic                    fips,
    output logic                    buffer_full,
    output logic [MAX_RATE-1:0]     out,
    output logic                    out_ready,
    output logic                    out_last,
    input  logic                    f_ack
);

    localparam int MAX_W = MAX_RATE / W;
    localparam int CNT_W = $clog2(MAX_W + 1);

    state_e              state;
    state_e              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                latched;
    logic [1:0]          mode_q;
    logic                fips_q;
    logic                last_q;
    logic [MAX_RATE-1:0] blk;
    logic [MAX_RATE-1:0] blk_nxt;

    logic [1:0]          eff_mode;
    logic                eff_fips;
    logic [CNT_W-1:0]    rate_w;
    logic [7:0]          domain;
    logic                acc;
    logic                final_pos;
    logic                fill_done;
    logic [W-1:0]        padded;

    // The first accepted word of a message uses the live mode/fips; later words use the latched copy.
    assign eff_mode  = latched ? mode_q : mode;
    assign eff_fips  = latched ? fips_q : fips;
    assign rate_w    = CNT_W'(int'(rate_bits(eff_mode)) / W);
    assign domain    = eff_fips ? DOMAIN_SHA3 : DOMAIN_KECCAK;
    assign acc       = (state == ACCEPT) && in_ready;
    assign final_pos = (cnt == rate_w - CNT_W'(1));
    assign fill_done = ((cnt + CNT_W'(1)) == rate_w);

    sha3_pad_word #(
        .W (W)
    ) u_pad (
        .word      (in),
        .byte_num  (byte_num),
        .domain    (domain),
        .final_pos (final_pos),
        .padded    (padded)
    );

    // Next block contents: write the accepted word at cnt; on the last word also set the pad-end bit.
    always_comb begin
        blk_nxt = blk;
        if (acc) begin
            if (is_last) begin
                blk_nxt[int'(cnt)*W +: W] = padded;
                if (!final_pos) begin
                    blk_nxt[int'(rate_w)*W-8 +: 8] = blk_nxt[int'(rate_w)*W-8 +: 8] | PAD_END;
                end
            end else begin
                blk_nxt[int'(cnt)*W +: W] = in;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt   = state;
        out_ready   = 1'b0;
        buffer_full = 1'b0;
        case (state)
            ACCEPT: begin
                if (acc && (is_last || fill_done)) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                out_ready   = 1'b1;
                buffer_full = 1'b1;
                if (f_ack) begin
                    state_nxt = last_q ? DONE : ACCEPT;
                end
            end
            DONE: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = ACCEPT;
            end
        endcase
    end

    assign out      = blk;
    assign out_last = last_q;

    // Block register, word counter and per-message mode latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blk     <= '0;
            cnt     <= '0;
            last_q  <= 1'b0;
            latched <= 1'b0;
            mode_q  <= 2'd0;
            fips_q  <= 1'b0;
        end else if (acc) begin
            blk <= blk_nxt;
            cnt <= cnt + CNT_W'(1);
            if (is_last) begin
                last_q <= 1'b1;
            end
            if (!latched) begin
                latched <= 1'b1;
                mode_q  <= mode;
                fips_q  <= fips;
            end
        end else if ((state == FULL) && f_ack) begin
            blk    <= '0;
            cnt    <= '0;
            last_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha3_padder_multi.sv
module tb_sha3_padder_multi;

    typedef struct packed {
        logic [1151:0] blk;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;

    logic [63:0]   in64;
    logic          inrdy64, last64, fips64, ack64;
    logic [2:0]    bn64;
    logic [1:0]    mode64;
    logic          full64, ordy64, olast64;
    logic [1151:0] out64;

    logic [31:0]   in32;
    logic          inrdy32, last32, fips32, ack32;
    logic [1:0]    bn32;
    logic [1:0]    mode32;
    logic          full32, ordy32, olast32;
    logic [1151:0] out32;

    exp_t q64[$];
    exp_t q32[$];
    exp_t e;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sha3_padder_multi #(.W(64), .MAX_RATE(1152)) u64 (
        .clk(clk), .reset(reset), .in(in64), .in_ready(inrdy64), .is_last(last64),
        .byte_num(bn64), .mode(mode64), .fips(fips64), .buffer_full(full64),
        .out(out64), .out_ready(ordy64), .out_last(olast64), .f_ack(ack64)
    );

    sha3_padder_multi #(.W(32), .MAX_RATE(1152)) u32 (
        .clk(clk), .reset(reset), .in(in32), .in_ready(inrdy32), .is_last(last32),
        .byte_num(bn32), .mode(mode32), .fips(fips32), .buffer_full(full32),
        .out(out32), .out_ready(ordy32), .out_last(olast32), .f_ack(ack32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [1151:0] act, input logic act_last, input exp_t x);
        int k = -1;
        n_cmp++;
        for (int j = 17; j >= 0; j--) begin
            if (act[j*64 +: 64] !== x.blk[j*64 +: 64]) k = j;
        end
        if (k >= 0) begin
            n_fail++;
            $display("FAIL %s word64 %0d: got %h, want %h", name, k, act[k*64 +: 64], x.blk[k*64 +: 64]);
        end else if (act_last !== x.last) begin
            n_fail++;
            $display("FAIL %s out_last: got %b, want %b", name, act_last, x.last);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        inrdy64 = 1'b0; last64 = 1'b0; ack64 = 1'b0;
        inrdy32 = 1'b0; last32 = 1'b0; ack32 = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic send64(input logic [63:0] w, input logic l, input logic [2:0] bn);
        in64 = w; inrdy64 = 1'b1; last64 = l; bn64 = bn;
        step();
        inrdy64 = 1'b0; last64 = 1'b0;
    endtask

    task automatic send32(input logic [31:0] w, input logic l, input logic [1:0] bn);
        in32 = w; inrdy32 = 1'b1; last32 = l; bn32 = bn;
        step();
        inrdy32 = 1'b0; last32 = 1'b0;
    endtask

    task automatic ack_64();
        ack64 = 1'b1;
        step();
        ack64 = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        in64 = '0; inrdy64 = 1'b0; last64 = 1'b0; bn64 = '0; mode64 = 2'd0; fips64 = 1'b0; ack64 = 1'b0;
        in32 = '0; inrdy32 = 1'b0; last32 = 1'b0; bn32 = '0; mode32 = 2'd0; fips32 = 1'b0; ack32 = 1'b0;
        fork
            // Monitor: compare every presented block against the head of its queue, pop when it is released.
            begin : monitor
                logic p64, p32;
                p64 = 1'b0;
                p32 = 1'b0;
                forever begin
                    @(negedge clk);
                    if (ordy64) begin
                        if (q64.size() == 0) begin
                            n_cmp++; n_fail++;
                            $display("FAIL blk64_unexpected: got out_ready=1, want 0");
                        end else begin
                            chk_blk("blk64", out64, olast64, q64[0]);
                        end
                    end else if (p64 && q64.size() != 0) begin
                        q64.delete(0);
                    end
                    if (ordy32) begin
                        if (q32.size() == 0) begin
                            n_cmp++; n_fail++;
                            $display("FAIL blk32_unexpected: got out_ready=1, want 0");
                        end else begin
                            chk_blk("blk32", out32, olast32, q32[0]);
                        end
                    end else if (p32 && q32.size() != 0) begin
                        q32.delete(0);
                    end
                    p64 = ordy64;
                    p32 = ordy32;
                end
            end
            begin : stimulus
                // Reset state.
                do_reset();
                chk("rst_out", 64'(|out64), 64'd0);
                chk("rst_out_ready", 64'(ordy64), 64'd0);
                chk("rst_out_last", 64'(olast64), 64'd0);
                chk("rst_buffer_full", 64'(full64), 64'd0);
                chk("rst_cnt", 64'(u64.cnt), 64'd0);

                // Short single-word message, mode 512, Keccak domain; second word offered while FULL.
                mode64 = 2'd3; fips64 = 1'b0;
                e = '0;
                e.blk[63:0]    = 64'h000001A5A4A3A2A1;
                e.blk[575:568] = 8'h80;
                e.last = 1'b1;
                q64.push_back(e);
                send64(64'h000000A5A4A3A2A1, 1'b1, 3'd5);
                in64 = 64'h0000000012345678; inrdy64 = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    chk("t1_full_hold", 64'(full64), 64'd1);
                    step();
                end
                ack_64();
                chk("t1_ack_full", 64'(full64), 64'd0);
                chk("t1_ack_ready", 64'(ordy64), 64'd0);
                chk("t1_ack_out", 64'(|out64), 64'd0);
                step();
                step();
                chk("t1_done_ready", 64'(ordy64), 64'd0);
                chk("t1_done_full", 64'(full64), 64'd0);
                inrdy64 = 1'b0;

                // Empty message, mode 256, SHA-3 domain.
                do_reset();
                mode64 = 2'd1; fips64 = 1'b1;
                e = '0;
                e.blk[7:0]       = 8'h06;
                e.blk[1087:1080] = 8'h80;
                e.last = 1'b1;
                q64.push_back(e);
                send64(64'hDEADBEEFCAFEF00D, 1'b1, 3'd0);
                step();
                ack_64();

                // Final byte shares the pad-end byte: 0x81.
                do_reset();
                mode64 = 2'd3; fips64 = 1'b0;
                for (int i = 0; i < 8; i++) send64(64'h1234567890ABCDEF, 1'b0, 3'd0);
                chk("t3_8w_full", 64'(full64), 64'd0);
                chk("t3_8w_ready", 64'(ordy64), 64'd0);
                e = '0;
                for (int i = 0; i < 8; i++) e.blk[i*64 +: 64] = 64'h1234567890ABCDEF;
                e.blk[575:512] = 64'h8134567890ABCDEF;
                e.last = 1'b1;
                q64.push_back(e);
                send64(64'h1234567890ABCDEF, 1'b1, 3'd7);
                step();
                ack_64();

                // Two blocks: backpressure while FULL, mode change mid-message ignored.
                do_reset();
                mode64 = 2'd3; fips64 = 1'b0;
                e = '0;
                for (int i = 0; i < 9; i++) e.blk[i*64 +: 64] = 64'h0101010101010101 * 64'(i + 1);
                e.last = 1'b0;
                q64.push_back(e);
                for (int i = 0; i < 9; i++) send64(64'h0101010101010101 * 64'(i + 1), 1'b0, 3'd0);
                chk("t4_blk1_last", 64'(olast64), 64'd0);
                chk("t4_blk1_full", 64'(full64), 64'd1);
                in64 = 64'hBADBADBADBADBAD0; inrdy64 = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("t4_held_full", 64'(full64), 64'd1);
                end
                inrdy64 = 1'b0;
                mode64 = 2'd0;
                ack_64();
                chk("t4_ack_full", 64'(full64), 64'd0);
                chk("t4_ack_out", 64'(|out64), 64'd0);
                e = '0;
                e.blk[7:0]     = 8'h01;
                e.blk[575:568] = 8'h80;
                e.last = 1'b1;
                q64.push_back(e);
                send64(64'hFFFFFFFFFFFFFFFF, 1'b1, 3'd0);
                step();
                ack_64();

                // Reset mid-message, then the empty-message case again under mode 256.
                do_reset();
                mode64 = 2'd0; fips64 = 1'b0;
                for (int i = 0; i < 3; i++) send64(64'hA5A5A5A5A5A5A5A5, 1'b0, 3'd0);
                do_reset();
                chk("t5_rst_out", 64'(|out64), 64'd0);
                chk("t5_rst_ready", 64'(ordy64), 64'd0);
                chk("t5_rst_full", 64'(full64), 64'd0);
                chk("t5_rst_cnt", 64'(u64.cnt), 64'd0);
                mode64 = 2'd1; fips64 = 1'b1;
                e = '0;
                e.blk[7:0]       = 8'h06;
                e.blk[1087:1080] = 8'h80;
                e.last = 1'b1;
                q64.push_back(e);
                send64(64'hDEADBEEFCAFEF00D, 1'b1, 3'd0);
                step();
                ack_64();

                // W=32 instance, mode 384: 26-word rate.
                do_reset();
                mode32 = 2'd2; fips32 = 1'b0;
                for (int i = 0; i < 25; i++) send32(32'hC0000000 | 32'(i), 1'b0, 2'd0);
                chk("t6_25w_ready", 64'(ordy32), 64'd0);
                chk("t6_25w_full", 64'(full32), 64'd0);
                e = '0;
                for (int i = 0; i < 25; i++) e.blk[i*32 +: 32] = 32'hC0000000 | 32'(i);
                e.blk[831:800] = 32'h80015A5B;
                e.last = 1'b1;
                q32.push_back(e);
                send32(32'hFFFF5A5B, 1'b1, 2'd2);
                chk("t6_26w_ready", 64'(ordy32), 64'd1);
                step();
                ack32 = 1'b1;
                step();
                ack32 = 1'b0;
                step();
                step();
            end
        join_any
        chk("q64_drained", 64'(q64.size()), 64'd0);
        chk("q32_drained", 64'(q32.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
